// File: rtl/pc_pkg.sv
// Shared types and alignment helpers for the program-counter sequencer.
// Imported by pc_target_calc and pc_sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP
    } state_e;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        JAL,
        JALR,
        MRET
    } next_sel_e;

    // Alignment checks only ever look at this many low address bits.
    localparam int unsigned MAX_ALIGN = 8;

    function automatic logic [MAX_ALIGN-1:0] align_mask(input int unsigned align);
        return MAX_ALIGN'((1 << align) - 1);
    endfunction

    function automatic logic is_misaligned(input logic [MAX_ALIGN-1:0] lsbs,
                                           input int unsigned align);
        return (lsbs & align_mask(align)) != '0;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: picks the highest-priority control, forms its
// target address and flags a non-sequential target that breaks instruction alignment.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int INST_ALIGN = 2
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic            zero,
    input  logic            jal,
    input  logic            jalr,
    input  logic            mret,
    output logic [XLEN-1:0] target,
    output next_sel_e       sel,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] STEP      = XLEN'(1) << INST_ALIGN;
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic taken;

    assign taken = branch & (zero ^ branch_ne);

    // NOTE: every output gets a default before the priority chain, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sel    = SEQ;
        target = pc + STEP;
        if (mret) begin
            sel    = MRET;
            target = epc;
        end else if (jalr) begin
            sel    = JALR;
            target = (rs1 + imm) & JALR_MASK;
        end else if (jal) begin
            sel    = JAL;
            target = pc + (imm << 1);
        end else if (taken) begin
            sel    = BR;
            target = pc + (imm << 1);
        end
        misaligned = (sel != SEQ) && is_misaligned(target[MAX_ALIGN-1:0], INST_ALIGN);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC/epc registers, boot delay, stall hold and a
// one-cycle trap state entered when a jump or branch lands on a misaligned address.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              BOOT_CYCLES  = 2,
    parameter int              INST_ALIGN   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic            zero,
    input  logic            jal,
    input  logic            jalr,
    input  logic            mret,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_link,
    output logic            fetch_valid,
    output logic            trap,
    output logic [XLEN-1:0] epc
);

    localparam logic [XLEN-1:0] STEP   = XLEN'(1) << INST_ALIGN;
    localparam int              BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST =
        BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    // With no boot delay the sequencer leaves reset already fetching.
    localparam state_e RESET_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic              trap_q, trap_d;
    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;

    logic [XLEN-1:0]   target;
    next_sel_e         sel;
    logic              misaligned;

    pc_target_calc #(
        .XLEN       (XLEN),
        .INST_ALIGN (INST_ALIGN)
    ) u_target_calc (
        .pc         (pc_q),
        .epc        (epc_q),
        .imm        (imm),
        .rs1        (rs1),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .zero       (zero),
        .jal        (jal),
        .jalr       (jalr),
        .mret       (mret),
        .target     (target),
        .sel        (sel),
        .misaligned (misaligned)
    );

    // NOTE: non-blocking assignments let every flop sample pre-edge values,
    // independent of the order the statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            trap_q     <= 1'b0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            trap_q     <= trap_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        trap_d     = 1'b0;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                boot_cnt_d = boot_cnt_q + 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (misaligned && sel != SEQ) begin
                        epc_d   = pc_q;
                        pc_d    = TRAP_VECTOR;
                        trap_d  = 1'b1;
                        state_d = TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            TRAP: begin
                // Handler fetch starts at TRAP_VECTOR on the following RUN cycle.
                state_d = RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign pc_link     = pc_q + STEP;
    assign fetch_valid = (state_q == RUN);
    assign trap        = trap_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: stimulus pushes the expected state of each
// cycle into a scoreboard queue, a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall, branch, branch_ne, zero, jal, jalr, mret;
    logic [63:0] imm, rs1;

    logic [63:0] pc0, link0, epc0;
    logic        fv0, trap0;
    logic [63:0] pc1, link1, epc1;
    logic        fv1, trap1;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        int          w;
        logic [63:0] pc;
        logic        fv;
        logic        tr;
        logic [63:0] epc;
        logic [63:0] link;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    localparam logic [7:0] C_0  = 8'h00;
    localparam logic [7:0] C_R  = 8'h80;
    localparam logic [7:0] C_S  = 8'h40;
    localparam logic [7:0] C_BR = 8'h20;
    localparam logic [7:0] C_NE = 8'h10;
    localparam logic [7:0] C_Z  = 8'h08;
    localparam logic [7:0] C_J  = 8'h04;
    localparam logic [7:0] C_JR = 8'h02;
    localparam logic [7:0] C_M  = 8'h01;

    pc_sequencer #(
        .XLEN(64), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100),
        .BOOT_CYCLES(2), .INST_ALIGN(2)
    ) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_ne(branch_ne), .zero(zero), .jal(jal), .jalr(jalr), .mret(mret),
        .imm(imm), .rs1(rs1), .pc(pc0), .pc_link(link0), .fetch_valid(fv0),
        .trap(trap0), .epc(epc0)
    );

    pc_sequencer #(
        .XLEN(64), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100),
        .BOOT_CYCLES(2), .INST_ALIGN(1)
    ) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_ne(branch_ne), .zero(zero), .jal(jal), .jalr(jalr), .mret(mret),
        .imm(imm), .rs1(rs1), .pc(pc1), .pc_link(link1), .fetch_valid(fv1),
        .trap(trap1), .epc(epc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld,
                         input logic [63:0] act, input logic [63:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp_v);
        end
    endtask

    // Applies controls for this cycle and queues the outputs expected during it.
    task automatic cyc(input string nm, input logic [7:0] ctl,
                       input logic [63:0] i_imm, input logic [63:0] i_rs1,
                       input int w, input logic [63:0] e_pc, input logic e_fv,
                       input logic e_tr, input logic [63:0] e_epc);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = ctl[7];
        stall     = ctl[6];
        branch    = ctl[5];
        branch_ne = ctl[4];
        zero      = ctl[3];
        jal       = ctl[2];
        jalr      = ctl[1];
        mret      = ctl[0];
        imm       = i_imm;
        rs1       = i_rs1;
        e.name = nm;
        e.w    = w;
        e.pc   = e_pc;
        e.fv   = e_fv;
        e.tr   = e_tr;
        e.epc  = e_epc;
        e.link = e_pc + ((w == 1) ? 64'd2 : 64'd4);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.w == 1) begin
                check(mon_e.name, "pc", pc1, mon_e.pc);
                check(mon_e.name, "fetch_valid", {63'd0, fv1}, {63'd0, mon_e.fv});
                check(mon_e.name, "trap", {63'd0, trap1}, {63'd0, mon_e.tr});
                check(mon_e.name, "epc", epc1, mon_e.epc);
                check(mon_e.name, "pc_link", link1, mon_e.link);
            end else begin
                check(mon_e.name, "pc", pc0, mon_e.pc);
                check(mon_e.name, "fetch_valid", {63'd0, fv0}, {63'd0, mon_e.fv});
                check(mon_e.name, "trap", {63'd0, trap0}, {63'd0, mon_e.tr});
                check(mon_e.name, "epc", epc0, mon_e.epc);
                check(mon_e.name, "pc_link", link0, mon_e.link);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        {stall, branch, branch_ne, zero, jal, jalr, mret} = '0;
        imm = '0;
        rs1 = '0;

        // Reset and boot delay, then sequential fetch.
        cyc("rst",        C_R,  0, 0, 0, 64'h0,   0, 0, 64'h0);
        cyc("boot_a",     C_0,  0, 0, 0, 64'h0,   0, 0, 64'h0);
        cyc("boot_b",     C_0,  0, 0, 0, 64'h0,   0, 0, 64'h0);
        cyc("run0",       C_0,  0, 0, 0, 64'h0,   1, 0, 64'h0);
        cyc("seq4",       C_0,  0, 0, 0, 64'h4,   1, 0, 64'h0);
        cyc("seq8",       C_0,  0, 0, 0, 64'h8,   1, 0, 64'h0);
        cyc("seqC",       C_0,  0, 0, 0, 64'hC,   1, 0, 64'h0);
        // Branches: beq taken, beq not taken, bne taken backwards, bne not taken.
        cyc("at10",       C_BR|C_Z,       4, 0, 0, 64'h10, 1, 0, 64'h0);
        cyc("beq_tk",     C_BR,           4, 0, 0, 64'h18, 1, 0, 64'h0);
        cyc("beq_nt",     C_BR|C_NE,     -64'd2, 0, 0, 64'h1C, 1, 0, 64'h0);
        cyc("bne_tk",     C_BR|C_NE|C_Z, -64'd2, 0, 0, 64'h18, 1, 0, 64'h0);
        cyc("bne_nt",     C_J,            2, 0, 0, 64'h1C, 1, 0, 64'h0);
        // jalr aligned, then jalr to a misaligned address traps.
        cyc("jal20",      C_JR,     3, 64'h101, 0, 64'h20,  1, 0, 64'h0);
        cyc("jalr104",    C_JR,     0, 64'h102, 0, 64'h104, 1, 0, 64'h0);
        cyc("trap_in",    C_J|C_S,  8, 0,       0, 64'h100, 0, 1, 64'h104);
        cyc("trap_out",   C_0,      0, 0,       0, 64'h100, 1, 0, 64'h104);
        cyc("hdl104",     C_0,      0, 0,       0, 64'h104, 1, 0, 64'h104);
        // All controls at once: mret wins.
        cyc("hdl108",     C_J|C_BR|C_Z|C_JR|C_M, 4, 64'h200, 0, 64'h108, 1, 0, 64'h104);
        cyc("mret_win",   C_S|C_J,  64'h40, 0,  0, 64'h104, 1, 0, 64'h104);
        cyc("stall_a",    C_S,      0, 0,       0, 64'h104, 1, 0, 64'h104);
        cyc("stall_b",    C_J|C_JR, 64'h10, 64'h300, 0, 64'h104, 1, 0, 64'h104);
        cyc("jalr_win",   C_J|C_BR|C_Z, 64'h10, 0, 0, 64'h310, 1, 0, 64'h104);
        // Wrap-around at the top of the address space.
        cyc("jal_win",    C_JR,    -64'd4, 0,   0, 64'h330, 1, 0, 64'h104);
        cyc("top",        C_0,      0, 0,       0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h104);
        cyc("wrap0",      C_0,      0, 0,       0, 64'h0,   1, 0, 64'h104);
        cyc("wrap4",      C_J,      1, 0,       0, 64'h4,   1, 0, 64'h104);
        cyc("jal_mis",    C_0,      0, 0,       0, 64'h100, 0, 1, 64'h4);
        // Reset lands inside the trap cycle.
        @(negedge clk);
        #2;
        reset = 1'b1;
        cyc("rst_trap",   C_R,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("rst_trap_b", C_0,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("boot2_b",    C_0,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("run2",       C_J,  64'h20, 0,      0, 64'h0,   1, 0, 64'h0);
        cyc("at40",       C_0,      0, 0,       0, 64'h40,  1, 0, 64'h0);
        // Asynchronous reset mid-run: takes effect before the next edge.
        cyc("rst_async",  C_R,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("boot3_a",    C_0,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("boot3_b",    C_0,      0, 0,       0, 64'h0,   0, 0, 64'h0);
        cyc("run3_0",     C_0,      0, 0,       0, 64'h0,   1, 0, 64'h0);
        cyc("run3_4",     C_0,      0, 0,       0, 64'h4,   1, 0, 64'h0);
        cyc("run3_8",     C_0,      0, 0,       0, 64'h8,   1, 0, 64'h0);
        // Compressed-alignment instance.
        cyc("c_rst",      C_R,      0, 0,       1, 64'h0,   0, 0, 64'h0);
        cyc("c_boot_a",   C_0,      0, 0,       1, 64'h0,   0, 0, 64'h0);
        cyc("c_boot_b",   C_0,      0, 0,       1, 64'h0,   0, 0, 64'h0);
        cyc("c_run0",     C_J,      1, 0,       1, 64'h0,   1, 0, 64'h0);
        cyc("c_jal2",     C_JR,     4, 64'h11,  1, 64'h2,   1, 0, 64'h0);
        cyc("c_jalr14",   C_0,      0, 0,       1, 64'h14,  1, 0, 64'h0);
        cyc("c_seq16",    C_M,      0, 0,       1, 64'h16,  1, 0, 64'h0);
        cyc("c_mret0",    C_0,      0, 0,       1, 64'h0,   1, 0, 64'h0);

        @(negedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
